// File: rtl/apb_exe_master.sv
// APB initiator for the execution unit: writes ARG_A, ARG_B, OP, then reads RESULT and STATUS.
// Reports completion with a one-cycle done pulse carrying the result, ALU error and bus-error flags.
module apb_exe_master #(
  parameter int M       = 8,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [M-1:0]      i_argA,
  input  logic [M-1:0]      i_argB,
  input  logic [3:0]        i_op,
  output logic              o_busy,
  output logic              o_done,
  output logic [M-1:0]      o_y,
  output logic              o_error,
  output logic              o_bus_err,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [M-1:0]      o_pwdata,
  input  logic [M-1:0]      i_prdata,
  input  logic              i_pready,
  input  logic              i_pslverr
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] TIMEOUT_V = WW'(TIMEOUT);
  localparam logic [2:0]    STEP_RES  = 3'd3;
  localparam logic [2:0]    STEP_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_r;
  logic [2:0]    step_r;
  logic [WW-1:0] wait_r;
  logic [M-1:0]  a_r;
  logic [M-1:0]  b_r;
  logic [3:0]    op_r;
  logic [M-1:0]  res_r;
  logic          err_r;
  logic [2:0]    step_nx_s;
  logic [WW-1:0] wait_nx_s;

  // Write data for each step; read steps drive zero.
  function automatic logic [M-1:0] wdata_for(input logic [2:0] s, input logic [M-1:0] a,
                                             input logic [M-1:0] b, input logic [3:0] op);
    case (s)
      3'd0:    return a;
      3'd1:    return b;
      3'd2:    return M'(op);
      default: return {M{1'b0}};
    endcase
  endfunction

  assign step_nx_s = step_r + 3'd1;
  assign wait_nx_s = wait_r + WW'(1);

  // Command sequencer: five APB transfers, then a one-cycle completion report.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= IDLE;
      step_r    <= 3'd0;
      wait_r    <= '0;
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= 4'd0;
      res_r     <= '0;
      err_r     <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_y       <= '0;
      o_error   <= 1'b0;
      o_bus_err <= 1'b0;
      o_paddr   <= '0;
      o_psel    <= 1'b0;
      o_penable <= 1'b0;
      o_pwrite  <= 1'b0;
      o_pwdata  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start) begin
            state_r   <= SETUP;
            o_busy    <= 1'b1;
            a_r       <= i_argA;
            b_r       <= i_argB;
            op_r      <= i_op;
            step_r    <= 3'd0;
            o_psel    <= 1'b1;
            o_penable <= 1'b0;
            o_paddr   <= '0;
            o_pwrite  <= 1'b1;
            o_pwdata  <= i_argA;
          end
        end
        SETUP: begin
          wait_r    <= '0;
          o_penable <= 1'b1;
          state_r   <= ACCESS;
        end
        ACCESS: begin
          if (i_pready) begin
            if (i_pslverr) begin
              state_r   <= DONE;
              o_done    <= 1'b1;
              o_bus_err <= 1'b1;
              o_psel    <= 1'b0;
              o_penable <= 1'b0;
              o_paddr   <= '0;
              o_pwrite  <= 1'b0;
              o_pwdata  <= '0;
            end else begin
              if (step_r == STEP_RES) begin
                res_r <= i_prdata;
              end
              if (step_r == STEP_LAST) begin
                err_r <= i_prdata[0];
              end
              if (step_r != STEP_LAST) begin
                step_r    <= step_nx_s;
                state_r   <= SETUP;
                o_penable <= 1'b0;
                o_paddr   <= ADDR_W'(step_nx_s);
                o_pwrite  <= (step_nx_s < STEP_RES);
                o_pwdata  <= wdata_for(step_nx_s, a_r, b_r, op_r);
              end else begin
                // STATUS arrives on this edge, so commit it directly rather than via err_r.
                state_r   <= DONE;
                o_done    <= 1'b1;
                o_y       <= res_r;
                o_error   <= i_prdata[0];
                o_bus_err <= 1'b0;
                o_psel    <= 1'b0;
                o_penable <= 1'b0;
                o_paddr   <= '0;
                o_pwrite  <= 1'b0;
                o_pwdata  <= '0;
              end
            end
          end else if (wait_nx_s == TIMEOUT_V) begin
            state_r   <= DONE;
            o_done    <= 1'b1;
            o_bus_err <= 1'b1;
            o_psel    <= 1'b0;
            o_penable <= 1'b0;
            o_paddr   <= '0;
            o_pwrite  <= 1'b0;
            o_pwdata  <= '0;
          end else begin
            wait_r <= wait_nx_s;
          end
        end
        DONE: begin
          o_done  <= 1'b0;
          o_busy  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_exe_master.md
# apb_exe_master

APB initiator that drives one complete operation on the APB execution unit: it writes operand A, operand B and the opcode into the unit's registers, then reads back the result and status. It sits between a local command interface (test sequencer or CPU-side logic) and the APB bus. Each accepted command runs as a fixed five-transfer sequence. Completion is reported as a one-cycle done pulse carrying the result, the ALU ERROR flag and a bus-error flag.

## Interface
- M, 8, operand/data width (M >= 4)
- ADDR_W, 4, APB address width
- TIMEOUT, 16, maximum ACCESS cycles with i_pready low before abort (>= 1)

- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_start  in  1  command request, sampled only when o_busy=0
- i_argA  in  M  operand A
- i_argB  in  M  operand B (bit index for bit ops)
- i_op  in  4  exe-unit opcode
- o_busy  out  1  high from the cycle after acceptance through the DONE cycle
- o_done  out  1  one-cycle completion pulse
- o_y  out  M  last committed result
- o_error  out  1  last committed ALU ERROR (status bit 0)
- o_bus_err  out  1  last operation aborted (PSLVERR or timeout)
- o_paddr  out  ADDR_W  APB address
- o_psel  out  1  APB select
- o_penable  out  1  APB enable
- o_pwrite  out  1  APB direction, 1 = write
- o_pwdata  out  M  APB write data
- i_prdata  in  M  APB read data
- i_pready  in  1  APB ready
- i_pslverr  in  1  APB slave error

## Operation
- Target register map: 0x0 ARG_A (W), 0x1 ARG_B (W), 0x2 OP (W, zero-extended to M), 0x3 RESULT (R), 0x4 STATUS (R, bit0 = ERROR).
- In IDLE, i_start=1 latches i_argA, i_argB and i_op, and clears the step counter to 0. i_start is ignored while o_busy=1.
- Steps 0..4 map to addresses 0x0..0x4. o_pwrite=1 for steps 0-2 and 0 for steps 3-4.
- FSM states:
  - IDLE -> SETUP on accepted i_start.
  - SETUP: psel=1, penable=0; always moves to ACCESS.
  - ACCESS: psel=1, penable=1.
    - If i_pready=1 and i_pslverr=0: step 3 captures i_prdata into the result shadow; step 4 captures i_prdata[0] into the error shadow. If step < 4, step increments and the FSM goes to SETUP; otherwise it goes to DONE.
    - If i_pready=1 and i_pslverr=1: abort, go to DONE with the abort flag set.
    - If i_pready=0: the wait counter increments. When it reaches TIMEOUT, abort and go to DONE with the abort flag set.
    - The wait counter clears on every SETUP.
  - DONE: o_done=1 for one cycle, then IDLE.
    - No abort: o_y and o_error take the shadow values and o_bus_err=0.
    - Abort: o_y and o_error keep their previous values and o_bus_err=1.
- Address, direction and write data stay stable from SETUP through the end of ACCESS.
- Outside SETUP/ACCESS: psel=0, penable=0, paddr=0, pwdata=0, pwrite=0.

## Timing
- Reset values: every output 0; FSM in IDLE; step counter, wait counter, shadows and latched operands all 0.
- Zero wait states: i_start sampled at edge k gives SETUP during cycle k+1. Five transfers of 2 cycles each occupy cycles k+1..k+10. o_done=1 during cycle k+11. The next i_start can be accepted at the end of cycle k+12 (IDLE).
- Each low-i_pready cycle adds exactly one cycle to that transfer.
- Timeout: o_done rises TIMEOUT+1 cycles after SETUP of the stalled transfer. psel/penable are low in DONE.
- i_pslverr is ignored when i_pready=0.
- i_rst=1 mid-transfer: psel/penable are 0 in the next cycle, no o_done, outputs return to reset values.
- i_start held high continuously: a new operation is accepted each time the FSM is in IDLE.
- Changes on i_argA/i_argB/i_op after acceptance have no effect.

## Test plan
- No wait states, A=0x05, B=3, op=SET, target returns RESULT=0x0D, STATUS=0 -> write sequence 0x0/0x05, 0x1/0x03, 0x2/op; then reads 0x3 and 0x4; o_done at cycle k+11; o_y=0x0D, o_error=0, o_bus_err=0.
- STATUS read returns 0x01 (B=9, M=8) -> o_error=1, o_y equals RESULT read, o_bus_err=0.
- 3 wait states on the RESULT read -> o_done at k+14, values correct, pwdata/paddr stable through the stall.
- i_pslverr=1 on the OP write -> no reads issued, o_done one cycle later, o_bus_err=1, o_y/o_error unchanged from prior op.
- i_pready held 0 on ARG_B, TIMEOUT=16 -> abort after 16 ACCESS cycles, o_bus_err=1, then a clean next operation clears o_bus_err.
- i_rst asserted during step 2 ACCESS -> bus idle next cycle, all outputs 0, no o_done; a new i_start runs the full sequence.
